ifetch_line_reader: RTL and testbench

IFETCH_LINE_READER -- requirements
Module: ifetch_line_reader

---
 rtl/ifetch_line_reader.sv | 108 ++++++++++
 tb/tb_ifetch_line_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_line_reader.sv
// Instruction-fetch line reader: one 128-bit line read per miss, word select on the way out.
// Optional single-line buffer with tag compare is enabled by defining IFETCH_LINE_BUFFER_EN.
module ifetch_line_reader #(
   parameter int LINE_AW = 12
) (
   input  logic                 clkrst_core_clk,
   input  logic                 clkrst_core_rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [LINE_AW+3:0]   req_addr,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_word,
   output logic [127:0]         rsp_line,
   input  logic                 inval,
   output logic [LINE_AW-1:0]   ram_addr,
   output logic                 ram_en,
   input  logic [127:0]         ram_q
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e               state_q, state_d;
   logic [LINE_AW-1:0]   ram_addr_q;
   logic [1:0]           word_q;
   logic [127:0]         line_q;

   logic [LINE_AW-1:0]   req_line;
   logic                 accept;
   logic                 hit;
   logic                 miss_accept;
   logic [1:0]           unused_bits;

   assign req_line    = req_addr[LINE_AW+3:4];
   assign unused_bits = req_addr[1:0];
   assign accept      = req_valid && (state_q == IDLE);
   assign miss_accept = accept && !hit;

`ifdef IFETCH_LINE_BUFFER_EN
   logic                 buf_valid_q;
   logic [LINE_AW-1:0]   tag_q;

   // An invalidate in the accept cycle must not let a stale line hit.
   assign hit = buf_valid_q && !inval && (tag_q == req_line);

   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         buf_valid_q <= 1'b0;
         tag_q       <= '0;
      end else if (state_q == WAIT) begin
         buf_valid_q <= !inval;
         tag_q       <= ram_addr_q;
      end else if (inval) begin
         buf_valid_q <= 1'b0;
      end
   end
`else
   logic unused_inval;

   assign hit          = 1'b0;
   assign unused_inval = inval;
`endif

   // NOTE: sequential state uses non-blocking assignments and resets asynchronously;
   // blocking here would let later readers in the same edge see the new value.
   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = hit ? RESP : WAIT;
         WAIT:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == IDLE);
      rsp_valid = (state_q == RESP);
      ram_en    = miss_accept;
      ram_addr  = miss_accept ? req_line : ram_addr_q;
   end

   // The line buffer is reset as well, so rsp_line/rsp_word read zero out of reset.
   always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
      if (!clkrst_core_rst_n) begin
         ram_addr_q <= '0;
         word_q     <= '0;
         line_q     <= '0;
      end else begin
         if (miss_accept) ram_addr_q <= req_line;
         if (accept)      word_q     <= req_addr[3:2];
         if (state_q == WAIT) line_q <= ram_q;
      end
   end

   assign rsp_line = line_q;
   assign rsp_word = line_q[{word_q, 5'd0} +: 32];

endmodule

// File: tb/tb_ifetch_line_reader.sv
// Scoreboarded random bench for ifetch_line_reader with a behavioural RAM and line-buffer model.
module tb_ifetch_line_reader;

   localparam int LINE_AW = 12;
`ifdef IFETCH_LINE_BUFFER_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 req_valid = 1'b0;
   logic                 req_ready;
   logic [LINE_AW+3:0]   req_addr = '0;
   logic                 rsp_valid;
   logic                 rsp_ready = 1'b0;
   logic [31:0]          rsp_word;
   logic [127:0]         rsp_line;
   logic                 inval = 1'b0;
   logic [LINE_AW-1:0]   ram_addr;
   logic                 ram_en;
   logic [127:0]         ram_q = '0;

   ifetch_line_reader #(.LINE_AW(LINE_AW)) dut (
      .clkrst_core_clk   (clk),
      .clkrst_core_rst_n (rst_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_addr          (req_addr),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_word          (rsp_word),
      .rsp_line          (rsp_line),
      .inval             (inval),
      .ram_addr          (ram_addr),
      .ram_en            (ram_en),
      .ram_q             (ram_q)
   );

   always #5 clk = ~clk;

   logic [127:0] mem [0:(1<<LINE_AW)-1];
   always @(posedge clk) if (ram_en) ram_q <= mem[ram_addr];

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [127:0] line;
      logic [31:0]  word;
   } rsp_t;
   rsp_t exp_q[$];

   bit                 buf_valid_m = 1'b0;
   logic [LINE_AW-1:0] buf_tag_m = '0;
   logic [LINE_AW-1:0] last_addr_m = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: compares every handshaken response against the scoreboard and checks hold stability.
   bit           held = 1'b0;
   logic [127:0] h_line;
   logic [31:0]  h_word;
   initial forever begin
      @(negedge clk);
      #3;
      if (!rst_n || !rsp_valid) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold_line", rsp_line, h_line);
            check("hold_word", rsp_word, h_word);
         end
         if (rsp_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_rsp: got line %h, want no response", rsp_line);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check("rsp_line", rsp_line, e.line);
               check("rsp_word", rsp_word, e.word);
            end
            held = 1'b0;
         end else begin
            held   = 1'b1;
            h_line = rsp_line;
            h_word = rsp_word;
         end
      end
   end

   // Issue one request, optionally invalidating in the accept or WAIT cycle, and stall the consumer.
   task automatic fetch(input logic [LINE_AW+3:0] addr, input bit inval_acc,
                        input bit inval_wait, input int hold);
      logic [LINE_AW-1:0] ln;
      bit   hit;
      rsp_t e;
      int   cyc;
      ln = addr[LINE_AW+3:4];
      req_valid = 1'b1;
      req_addr  = addr;
      inval     = inval_acc;
      if (inval_acc) mem[ln] = rand128();
      hit = BUF_EN && buf_valid_m && (buf_tag_m == ln) && !inval_acc;
      #1;
      check("req_ready_idle", req_ready, 1'b1);
      check("ram_en_accept", ram_en, !hit);
      if (!hit) last_addr_m = ln;
      check("ram_addr_accept", ram_addr, last_addr_m);
      e.line = mem[ln];
      e.word = e.line[addr[3:2]*32 +: 32];
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      inval     = inval_wait;
      if (!hit) begin
         buf_valid_m = !inval_wait;
         buf_tag_m   = ln;
         if (inval_wait) mem[ln] = rand128();
      end else if (inval_wait) begin
         buf_valid_m = 1'b0;
      end
      cyc = 1;
      while (!rsp_valid && cyc < 6) begin
         @(negedge clk);
         inval = 1'b0;
         cyc++;
      end
      inval = 1'b0;
      check("latency", cyc, hit ? 1 : 2);
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'b1;
         req_addr  = LINE_AW'($urandom) << 4;
         rsp_ready = 1'b0;
         #1;
         check("hold_valid", rsp_valid, 1'b1);
         check("hold_req_ready", req_ready, 1'b0);
         check("hold_ram_en", ram_en, 1'b0);
         check("hold_ram_addr", ram_addr, last_addr_m);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check("post_rsp_valid", rsp_valid, 1'b0);
      check("post_req_ready", req_ready, 1'b1);
   endtask

   task automatic idle_inval();
      inval = 1'b1;
      mem[buf_tag_m] = rand128();
      buf_valid_m = 1'b0;
      @(negedge clk);
      inval = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_ram_en", ram_en, 1'b0);
      check("rst_ram_addr", ram_addr, '0);
      check("rst_rsp_line", rsp_line, '0);
      check("rst_rsp_word", rsp_word, '0);
   endtask

   task automatic reset_in_wait(input logic [LINE_AW+3:0] addr);
      req_valid = 1'b1;
      req_addr  = addr;
      #1;
      check("rw_ram_en", ram_en, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      check("rw_in_wait", rsp_valid, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      buf_valid_m = 1'b0;
      last_addr_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rw_stays_idle", rsp_valid, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, want finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < (1 << LINE_AW); i++) mem[i] = rand128();
      mem[12'h012] = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      @(negedge clk);

      fetch(16'h0124, 1'b0, 1'b0, 5);
      fetch(16'h012C, 1'b0, 1'b0, 0);
      fetch(16'h0200, 1'b0, 1'b1, 0);
      fetch(16'h0200, 1'b0, 1'b0, 1);
      reset_in_wait(16'h0350);
      fetch(16'h0010, 1'b0, 1'b0, 0);
      fetch(16'h0018, 1'b1, 1'b0, 0);

      for (int n = 0; n < 150; n++) begin
         logic [LINE_AW+3:0] a;
         a = {LINE_AW'(8'h10 + $urandom_range(0, 5)), 4'($urandom)};
         if ($urandom_range(0, 7) == 0) idle_inval();
         fetch(a, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3));
      end

      repeat (2) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
